// File: rtl/prog_counter_gen.sv
// WIDTH-bit programmable up/down counter with load, limit, four terminal-count
// modes, registered tc pulse, sticky one-shot done flag and a tri-state bus copy.
module prog_counter_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             oe,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] y_tri,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    FREE     = 2'b00,
    MODULO   = 2'b01,
    ONESHOT  = 2'b10,
    SATURATE = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] next_val;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             step;

  assign mode_s = mode_e'(mode);

  always_comb begin
    q_d      = q_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    next_val = dir ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
    if (!dir)
      term = '0;
    else if (mode_s == FREE)
      term = '1;
    else
      term = limit;
    // A completed one-shot blocks stepping only while mode stays ONESHOT.
    step = en && !((mode_s == ONESHOT) && done_q);

    if (load) begin
      q_d    = load_val;
      done_d = 1'b0;
    end else if (step) begin
      if (q_q != term) begin
        q_d = next_val;
      end else begin
        tc_d = 1'b1;
        unique case (mode_s)
          FREE:     q_d = next_val;
          MODULO:   q_d = dir ? '0 : limit;
          ONESHOT:  done_d = 1'b1;
          SATURATE: q_d = q_q;
          default:  q_d = q_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign q     = q_q;
  assign tc    = tc_q;
  assign done  = done_q;
  assign y_tri = oe ? q_q : 'z;

endmodule
